// File: rtl/decode_ctrl_stage.sv
// Registered main-decode stage: D-stage decode into the E register, plus HI/LO busy tracking and interlock.
// Optional feature macro: DECODE_RI_EXC_EN (reserved-instruction flag on ri_e).
module decode_ctrl_stage #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 36,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall_in,
  input  logic        flush_e,
  output logic [10:0] ctrl_e,
  output logic [1:0]  hilo_we_e,
  output logic        valid_e,
  output logic        ri_e,
  output logic        hilo_busy,
  output logic        hilo_stall
);

`ifdef DECODE_RI_EXC_EN
  localparam logic RI_EN = 1'b1;
`else
  localparam logic RI_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [10:0] C_RTYPE  = 11'h600;
  localparam logic [10:0] C_JALR   = 11'h604;
  localparam logic [10:0] C_JR     = 11'h014;
  localparam logic [10:0] C_LOAD   = 11'h560;
  localparam logic [10:0] C_STORE  = 11'h141;
  localparam logic [10:0] C_BRANCH = 11'h080;
  localparam logic [10:0] C_BAL    = 11'h482;
  localparam logic [10:0] C_IMM    = 11'h500;
  localparam logic [10:0] C_J      = 11'h010;
  localparam logic [10:0] C_JAL    = 11'h408;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  logic [5:0]       op_s;
  logic [5:0]       funct_s;
  logic [4:0]       rt_s;
  logic             unused_ok_s;

  logic [10:0]      dec_ctrl_s;
  logic [1:0]       dec_hilo_s;
  logic             dec_ri_s;
  logic             dec_hilo_op_s;
  logic             dec_mul_s;
  logic             dec_div_s;

  logic [10:0]      fin_ctrl_s;
  logic [1:0]       fin_hilo_s;
  logic             fin_ri_s;
  logic             hilo_stall_s;
  logic             capture_s;

  logic [10:0]      ctrl_r;
  logic [1:0]       hilo_we_r;
  logic             valid_r;
  logic             ri_r;
  logic [CNT_W-1:0] cnt_r;

  assign op_s        = instr_d[31:26];
  assign rt_s        = instr_d[20:16];
  assign funct_s     = instr_d[5:0];
  assign unused_ok_s = &{1'b0, instr_d[25:21], instr_d[15:6]};

  // Main decoder: opcode/funct/rt to control vector, HI/LO enables and reserved flag
  always_comb begin
    dec_ctrl_s    = 11'h000;
    dec_hilo_s    = 2'b00;
    dec_ri_s      = 1'b0;
    dec_hilo_op_s = 1'b0;
    dec_mul_s     = 1'b0;
    dec_div_s     = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        dec_ctrl_s = C_RTYPE;
        case (funct_s)
          FN_MTHI: begin
            dec_hilo_s    = 2'b10;
            dec_hilo_op_s = 1'b1;
          end
          FN_MTLO: begin
            dec_hilo_s    = 2'b01;
            dec_hilo_op_s = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            dec_hilo_op_s = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            dec_hilo_s    = 2'b11;
            dec_hilo_op_s = 1'b1;
            dec_mul_s     = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            dec_hilo_s    = 2'b11;
            dec_hilo_op_s = 1'b1;
            dec_div_s     = 1'b1;
          end
          FN_JALR: dec_ctrl_s = C_JALR;
          FN_JR:   dec_ctrl_s = C_JR;
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_SYSCALL, FN_BREAK,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            dec_ctrl_s = C_RTYPE;
          end
          default: dec_ri_s = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt_s)
          RT_BLTZ, RT_BGEZ:     dec_ctrl_s = C_BRANCH;
          RT_BLTZAL, RT_BGEZAL: dec_ctrl_s = C_BAL;
          default:              dec_ri_s   = 1'b1;
        endcase
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: dec_ctrl_s = C_LOAD;
      OP_SW, OP_SB, OP_SH:                 dec_ctrl_s = C_STORE;
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:    dec_ctrl_s = C_BRANCH;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_SLTI, OP_SLTIU:           dec_ctrl_s = C_IMM;
      OP_J:                                dec_ctrl_s = C_J;
      OP_JAL:                              dec_ctrl_s = C_JAL;
      default:                             dec_ri_s   = 1'b1;
    endcase
  end

  // Reserved-instruction gating and capture qualification; an invalid D slot captures as zeros
  always_comb begin
    fin_ctrl_s = 11'h000;
    fin_hilo_s = 2'b00;
    fin_ri_s   = 1'b0;
    if (valid_d) begin
      fin_ri_s = RI_EN & dec_ri_s;
      if (fin_ri_s) begin
        fin_ctrl_s = 11'h000;
        fin_hilo_s = 2'b00;
      end else begin
        fin_ctrl_s = dec_ctrl_s;
        fin_hilo_s = dec_hilo_s;
      end
    end else begin
      fin_ri_s = 1'b0;
    end
  end

  // Interlock is released combinationally by reset so a cleared counter never blocks D
  assign hilo_stall_s = rst & valid_d & dec_hilo_op_s & (cnt_r != CNT_ZERO);
  assign capture_s    = ~flush_e & ~stall_in & ~hilo_stall_s;

  // E-stage register with flush > stall > interlock bubble > capture priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_r    <= 11'h000;
      hilo_we_r <= 2'b00;
      valid_r   <= 1'b0;
      ri_r      <= 1'b0;
    end else if (flush_e || (!stall_in && hilo_stall_s)) begin
      ctrl_r    <= 11'h000;
      hilo_we_r <= 2'b00;
      valid_r   <= 1'b0;
      ri_r      <= 1'b0;
    end else if (stall_in) begin
      ctrl_r    <= ctrl_r;
      hilo_we_r <= hilo_we_r;
      valid_r   <= valid_r;
      ri_r      <= ri_r;
    end else begin
      ctrl_r    <= fin_ctrl_s;
      hilo_we_r <= fin_hilo_s;
      valid_r   <= valid_d;
      ri_r      <= fin_ri_s;
    end
  end

  // HI/LO busy counter: loads only when a MULT/DIV actually enters E, otherwise saturating decrement
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (capture_s && valid_d && !fin_ri_s && dec_mul_s) begin
      cnt_r <= CNT_MUL;
    end else if (capture_s && valid_d && !fin_ri_s && dec_div_s) begin
      cnt_r <= CNT_DIV;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  assign ctrl_e     = ctrl_r;
  assign hilo_we_e  = hilo_we_r;
  assign valid_e    = valid_r;
  assign ri_e       = ri_r;
  assign hilo_busy  = (cnt_r != CNT_ZERO);
  assign hilo_stall = hilo_stall_s;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed self-checking bench for decode_ctrl_stage; expectations are hand-computed constants.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        stall_in;
  logic        flush_e;
  logic [10:0] ctrl_e;
  logic [1:0]  hilo_we_e;
  logic        valid_e;
  logic        ri_e;
  logic        hilo_busy;
  logic        hilo_stall;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef DECODE_RI_EXC_EN
  localparam logic        RI_EXP    = 1'b1;
  localparam logic [10:0] RFUNC_EXP = 11'h000;
`else
  localparam logic        RI_EXP    = 1'b0;
  localparam logic [10:0] RFUNC_EXP = 11'h600;
`endif

  decode_ctrl_stage #(.MUL_CYCLES(2), .DIV_CYCLES(36), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_d    (instr_d),
    .valid_d    (valid_d),
    .stall_in   (stall_in),
    .flush_e    (flush_e),
    .ctrl_e     (ctrl_e),
    .hilo_we_e  (hilo_we_e),
    .valid_e    (valid_e),
    .ri_e       (ri_e),
    .hilo_busy  (hilo_busy),
    .hilo_stall (hilo_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0004};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_e(input string tag, input logic [10:0] c, input logic [1:0] h, input logic v);
    check_vec({tag, ".ctrl"},  {21'd0, ctrl_e},    {21'd0, c});
    check_vec({tag, ".hilo"},  {30'd0, hilo_we_e}, {30'd0, h});
    check_vec({tag, ".valid"}, {31'd0, valid_e},   {31'd0, v});
  endtask

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic [10:0] c;
    logic [1:0]  h;
  } vec_t;

  vec_t sweep[$];

  initial begin
    rst      = 1'b0;
    valid_d  = 1'b1;
    instr_d  = itype(6'h23, 5'd2);
    stall_in = 1'b0;
    flush_e  = 1'b0;

    // reset held with LW in D
    for (int i = 0; i < 2; i++) begin
      step();
      check_e("rst", 11'h000, 2'b00, 1'b0);
      check_vec("rst.ri",   {31'd0, ri_e},      32'd0);
      check_vec("rst.busy", {31'd0, hilo_busy}, 32'd0);
    end
    rst = 1'b1;
    step();
    check_e("rst_rel_lw", 11'h560, 2'b00, 1'b1);

    // decode sweep; DIV last so its busy window feeds the reset test
    sweep.push_back('{"sw",     itype(6'h2B, 5'd2),  11'h141, 2'b00});
    sweep.push_back('{"jal",    {6'h03, 26'h10},     11'h408, 2'b00});
    sweep.push_back('{"jr",     rtype(6'h08),        11'h014, 2'b00});
    sweep.push_back('{"jalr",   rtype(6'h09),        11'h604, 2'b00});
    sweep.push_back('{"bgezal", itype(6'h01, 5'h11), 11'h482, 2'b00});
    sweep.push_back('{"bltz",   itype(6'h01, 5'h00), 11'h080, 2'b00});
    sweep.push_back('{"beq",    itype(6'h04, 5'd2),  11'h080, 2'b00});
    sweep.push_back('{"lui",    itype(6'h0F, 5'd2),  11'h500, 2'b00});
    sweep.push_back('{"j",      {6'h02, 26'h20},     11'h010, 2'b00});
    sweep.push_back('{"lhu",    itype(6'h25, 5'd2),  11'h560, 2'b00});
    sweep.push_back('{"add",    rtype(6'h20),        11'h600, 2'b00});
    sweep.push_back('{"mthi",   rtype(6'h11),        11'h600, 2'b10});
    sweep.push_back('{"mtlo",   rtype(6'h13),        11'h600, 2'b01});
    sweep.push_back('{"mfhi",   rtype(6'h10),        11'h600, 2'b00});
    sweep.push_back('{"div",    rtype(6'h1A),        11'h600, 2'b11});
    foreach (sweep[k]) begin
      instr_d = sweep[k].ins;
      step();
      check_e(sweep[k].tag, sweep[k].c, sweep[k].h, 1'b1);
    end
    check_vec("div.busy", {31'd0, hilo_busy}, 32'd1);

    // reset mid-divide
    valid_d = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_vec("div5.busy", {31'd0, hilo_busy}, 32'd1);
    valid_d = 1'b1;
    instr_d = rtype(6'h10);
    #1;
    check_vec("div5.mfhi_stall", {31'd0, hilo_stall}, 32'd1);
    rst = 1'b0;
    #1;
    check_vec("rstlow.stall", {31'd0, hilo_stall}, 32'd0);
    step();
    check_vec("rstlow.busy", {31'd0, hilo_busy}, 32'd0);
    rst = 1'b1;
    #1;
    check_vec("post_rst.stall", {31'd0, hilo_stall}, 32'd0);
    step();
    check_e("post_rst_mfhi", 11'h600, 2'b00, 1'b1);

    // invalid D slot
    valid_d = 1'b0;
    instr_d = itype(6'h2B, 5'd2);
    step();
    check_e("invalid", 11'h000, 2'b00, 1'b0);

    // MULT then MFLO: two bubble edges then capture
    valid_d = 1'b1;
    instr_d = rtype(6'h18);
    step();
    check_e("mult", 11'h600, 2'b11, 1'b1);
    check_vec("mult.busy", {31'd0, hilo_busy}, 32'd1);
    instr_d = rtype(6'h12);
    #1;
    check_vec("mflo.stall0", {31'd0, hilo_stall}, 32'd1);
    step();
    check_e("mflo.bub1", 11'h000, 2'b00, 1'b0);
    check_vec("mflo.stall1", {31'd0, hilo_stall}, 32'd1);
    step();
    check_e("mflo.bub2", 11'h000, 2'b00, 1'b0);
    check_vec("mflo.stall2", {31'd0, hilo_stall}, 32'd0);
    check_vec("mflo.busy2",  {31'd0, hilo_busy},  32'd0);
    step();
    check_e("mflo.cap", 11'h600, 2'b00, 1'b1);

    // non-HI/LO op during busy is not stalled
    instr_d = rtype(6'h19);
    step();
    instr_d = rtype(6'h20);
    #1;
    check_vec("add_busy.stall", {31'd0, hilo_stall}, 32'd0);
    step();
    check_e("add_busy", 11'h600, 2'b00, 1'b1);
    check_vec("add_busy.busy", {31'd0, hilo_busy}, 32'd1);
    step();
    check_vec("add_busy.drain", {31'd0, hilo_busy}, 32'd0);

    // stall/flush priority
    instr_d = itype(6'h2B, 5'd2);
    step();
    check_e("pre_sf", 11'h141, 2'b00, 1'b1);
    stall_in = 1'b1;
    flush_e  = 1'b1;
    instr_d  = itype(6'h23, 5'd2);
    step();
    check_e("stall_flush", 11'h000, 2'b00, 1'b0);
    stall_in = 1'b0;
    flush_e  = 1'b0;
    instr_d  = itype(6'h2B, 5'd2);
    step();
    stall_in = 1'b1;
    instr_d  = itype(6'h23, 5'd2);
    step();
    check_e("stall_hold", 11'h141, 2'b00, 1'b1);
    stall_in = 1'b0;
    flush_e  = 1'b1;
    instr_d  = rtype(6'h1A);
    step();
    check_e("div_flush", 11'h000, 2'b00, 1'b0);
    check_vec("div_flush.busy", {31'd0, hilo_busy}, 32'd0);
    flush_e = 1'b0;

    // reserved encodings
    instr_d = {6'h3F, 26'd0};
    step();
    check_e("op3f", 11'h000, 2'b00, 1'b1);
    check_vec("op3f.ri", {31'd0, ri_e}, {31'd0, RI_EXP});
    instr_d = itype(6'h01, 5'h05);
    step();
    check_e("regimm05", 11'h000, 2'b00, 1'b1);
    check_vec("regimm05.ri", {31'd0, ri_e}, {31'd0, RI_EXP});
    instr_d = rtype(6'h3F);
    step();
    check_e("rfunc3f", RFUNC_EXP, 2'b00, 1'b1);
    check_vec("rfunc3f.ri", {31'd0, ri_e}, {31'd0, RI_EXP});
    instr_d = itype(6'h08, 5'd2);
    step();
    check_e("addi", 11'h500, 2'b00, 1'b1);
    check_vec("addi.ri", {31'd0, ri_e}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered main-decode stage for the 5-stage MIPS pipeline. Decodes the D-stage instruction into the 11-bit control vector plus HI/LO write enables, and registers them into the E stage.
- Adds what the combinational decoder lacks: a multi-cycle HI/LO occupancy counter for MULT/DIV, a HI/LO interlock stall, bubble insertion, and stall/flush handling.
- Sits between the instruction fetch/decode register and the ID/EX datapath register. Its stall output feeds the hazard unit.

Parameters:
- MUL_CYCLES, 2, cycles HI/LO stays busy after a MULT/MULTU issues into E; must be >=1.
- DIV_CYCLES, 36, cycles HI/LO stays busy after a DIV/DIVU issues into E; must be >=1.
- CNT_W, 6, busy-counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- instr_d  in  32  D-stage instruction.
- valid_d  in  1  instr_d holds a real instruction.
- stall_in  in  1  hazard-unit stall; holds the E register.
- flush_e  in  1  squash; E register loads a bubble.
- ctrl_e  out  11  registered control: [10]regwrite [9]regdst [8]alusrc [7]branch [6]memen [5]memtoreg [4]jump [3]jal [2]jr [1]bal [0]memwrite.
- hilo_we_e  out  2  registered {hi_we, lo_we}.
- valid_e  out  1  E holds a real instruction.
- ri_e  out  1  registered reserved-instruction flag (feature-dependent).
- hilo_busy  out  1  busy counter != 0.
- hilo_stall  out  1  combinational D-stage interlock request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Decode (combinational, opcode/funct/rt codes from defines.h). Values are {ctrl, hilo_we}:
  - R-type ALU default: 0x600, 00
  - MTHI: 0x600, 10
  - MTLO: 0x600, 01
  - MFHI, MFLO: 0x600, 00
  - MULT, MULTU, DIV, DIVU: 0x600, 11
  - JALR: 0x604
  - JR: 0x014
  - LW, LB, LBU, LH, LHU: 0x560
  - SW, SB, SH: 0x141
  - BEQ, BNE, BGTZ, BLEZ: 0x080
  - REGIMM BLTZ, BGEZ: 0x080
  - REGIMM BLTZAL, BGEZAL: 0x482
  - ADDI, ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU: 0x500
  - J: 0x010
  - JAL: 0x408
  - REGIMM with an unlisted rt, or any unlisted opcode: all zero. No latches.
- hilo_op_d: valid_d and funct is one of MFHI, MFLO, MTHI, MTLO, MULT*, DIV* under R-type.
- hilo_stall = rst & valid_d & hilo_op_d & hilo_busy.
- Register update at each posedge clk, priority order:
  1. rst==0: ctrl_e=0, hilo_we_e=0, valid_e=0, ri_e=0, counter=0.
  2. flush_e: bubble (all E outputs 0). Counter decrements if nonzero, no load.
  3. stall_in: E outputs hold. Counter decrements if nonzero, no load.
  4. hilo_stall: bubble. Counter decrements.
  5. Otherwise capture: valid_e=valid_d. ctrl_e/hilo_we_e/ri_e = decode if valid_d, else 0.
- Counter load on capture: MULT/MULTU loads MUL_CYCLES, DIV/DIVU loads DIV_CYCLES. Otherwise it decrements if nonzero.
- Counter boundaries:
  - Load and decrement never coincide, because a HI/LO op cannot capture while busy.
  - Counter saturates at 0 and never wraps.
- D→E latency is 1 cycle.
- Reset mid-divide clears the counter immediately; hilo_stall drops in the same cycle rst is low.

Optional Feature:
- Macro: DECODE_RI_EXC_EN.
- Defined: ri_e=1 for a captured valid instruction with an unlisted opcode, an unlisted REGIMM rt, or an R-type funct outside the MIPS-I integer set. Its ctrl_e is forced to 0.
- Undefined: ri_e is constant 0. Unlisted encodings decode to zero (R-type unlisted funct uses the R default 0x600).

Test Plan:
- Reset: hold rst=0 with valid_d=1, instr=LW for 2 cycles -> all outputs 0, hilo_busy=0. Release -> next edge ctrl_e=0x560, valid_e=1.
- Decode sweep: SW -> 0x141; JAL -> 0x408; JR -> 0x014; BGEZAL -> 0x482; MTHI -> 0x600/hilo_we_e=10; DIV -> 0x600/11. Each appears 1 cycle after presentation.
- Interlock: MULT captured, then MFLO held in D -> hilo_stall=1 and valid_e=0 for exactly MUL_CYCLES=2 edges, then MFLO captured. An ADD during busy captures with no stall.
- Stall/flush priority: stall_in=1 with flush_e=1 -> bubble. stall_in=1 alone -> E holds the prior value. DIV under flush_e -> counter stays 0.
- Reset mid-divide: DIV captured, rst=0 after 5 cycles -> counter 0 next edge, subsequent MFHI not stalled.
- Feature: with DECODE_RI_EXC_EN, opcode 0x3F valid -> ri_e=1, ctrl_e=0. Without it -> ri_e=0, ctrl_e=0. REGIMM rt=0x05 -> ctrl_e=0.
